// File: rtl/sub_share_arb.sv
// Round-robin arbiter sharing one registered subtract/flag datapath between two requesters.
// Each operation walks IDLE -> EXEC -> DONE; results and flags hold until the next EXEC.
module sub_share_arb #(
   parameter int WIDTH = 64
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req0,
   input  logic [WIDTH-1:0] a0,
   input  logic [WIDTH-1:0] b0,
   input  logic             req1,
   input  logic [WIDTH-1:0] a1,
   input  logic [WIDTH-1:0] b1,
   output logic             gnt0,
   output logic             gnt1,
   output logic             busy,
   output logic             done0,
   output logic             done1,
   output logic [WIDTH-1:0] result,
   output logic             zf,
   output logic             sf,
   output logic             of
);

   typedef enum logic [1:0] {
      IDLE,
      EXEC,
      DONE
   } state_t;

   state_t           state_q, state_d;
   logic             gnt0_q, gnt0_d;
   logic             gnt1_q, gnt1_d;
   logic             done0_q, done0_d;
   logic             done1_q, done1_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             zf_q, zf_d;
   logic             sf_q, sf_d;
   logic             of_q, of_d;
   logic [WIDTH-1:0] opa_q, opa_d;
   logic [WIDTH-1:0] opb_q, opb_d;
   logic             last_q, last_d;
   logic [WIDTH-1:0] diff;
   logic             sel1;

   always_comb begin
      state_d  = state_q;
      gnt0_d   = gnt0_q;
      gnt1_d   = gnt1_q;
      done0_d  = done0_q;
      done1_d  = done1_q;
      result_d = result_q;
      zf_d     = zf_q;
      sf_d     = sf_q;
      of_d     = of_q;
      opa_d    = opa_q;
      opb_d    = opb_q;
      last_d   = last_q;

      diff = opa_q + ~opb_q + WIDTH'(1);
      // last_q holds the index of the previous winner; on a tie the other one goes.
      sel1 = req1 & (~req0 | ~last_q);

      case (state_q)
         IDLE: begin
            if (req0 | req1) begin
               opa_d   = sel1 ? a1 : a0;
               opb_d   = sel1 ? b1 : b0;
               gnt0_d  = ~sel1;
               gnt1_d  = sel1;
               last_d  = sel1;
               state_d = EXEC;
            end
         end
         EXEC: begin
            result_d = diff;
            zf_d     = (diff == '0);
            sf_d     = diff[WIDTH-1];
            of_d     = (opa_q[WIDTH-1] & ~opb_q[WIDTH-1] & ~diff[WIDTH-1]) |
                       (~opa_q[WIDTH-1] & opb_q[WIDTH-1] & diff[WIDTH-1]);
            done0_d  = gnt0_q;
            done1_d  = gnt1_q;
            state_d  = DONE;
         end
         DONE: begin
            gnt0_d  = 1'b0;
            gnt1_d  = 1'b0;
            done0_d = 1'b0;
            done1_d = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         gnt0_q   <= 1'b0;
         gnt1_q   <= 1'b0;
         done0_q  <= 1'b0;
         done1_q  <= 1'b0;
         result_q <= '0;
         zf_q     <= 1'b0;
         sf_q     <= 1'b0;
         of_q     <= 1'b0;
         opa_q    <= '0;
         opb_q    <= '0;
         last_q   <= 1'b1;
      end else begin
         state_q  <= state_d;
         gnt0_q   <= gnt0_d;
         gnt1_q   <= gnt1_d;
         done0_q  <= done0_d;
         done1_q  <= done1_d;
         result_q <= result_d;
         zf_q     <= zf_d;
         sf_q     <= sf_d;
         of_q     <= of_d;
         opa_q    <= opa_d;
         opb_q    <= opb_d;
         last_q   <= last_d;
      end
   end

   assign gnt0   = gnt0_q;
   assign gnt1   = gnt1_q;
   assign done0  = done0_q;
   assign done1  = done1_q;
   assign busy   = (state_q == EXEC) || (state_q == DONE);
   assign result = result_q;
   assign zf     = zf_q;
   assign sf     = sf_q;
   assign of     = of_q;

endmodule

// File: tb/tb_sub_share_arb.sv
// Scoreboard bench for sub_share_arb: expected {owner,zf,sf,of,result} queued at request time,
// popped and compared whenever a done pulse appears.
module tb_sub_share_arb;

   logic        clk;
   logic        rst_n;
   logic        req0, req1;
   logic [63:0] a0, b0, a1, b1;
   logic        gnt0, gnt1, busy, done0, done1;
   logic [63:0] result;
   logic        zf, sf, of;

   int          n_checks;
   int          n_errs;
   logic [67:0] sb_q[$];
   logic [67:0] sb_exp;
   logic [3:0]  pat_sim [0:8];
   logic [3:0]  pat_rst [3:7];

   sub_share_arb #(.WIDTH(64)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .req0   (req0),
      .a0     (a0),
      .b0     (b0),
      .req1   (req1),
      .a1     (a1),
      .b1     (b1),
      .gnt0   (gnt0),
      .gnt1   (gnt1),
      .busy   (busy),
      .done0  (done0),
      .done1  (done1),
      .result (result),
      .zf     (zf),
      .sf     (sf),
      .of     (of)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errs++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [67:0] expect_sub(input logic owner, input logic [63:0] a,
                                              input logic [63:0] b);
      logic [63:0] r;
      logic        ovf;
      r   = a - b;
      ovf = (a[63] != b[63]) && (r[63] != a[63]);
      return {owner, (r == 64'd0), r[63], ovf, r};
   endfunction

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // Starts in an IDLE cycle just after a clock edge; ends after checking the cycle back in IDLE.
   task automatic run_op(input logic sel, input logic [63:0] a, input logic [63:0] b,
                         input logic [67:0] exp, input logic perturb);
      if (sel) begin
         req1 = 1'b1; a1 = a; b1 = b;
      end else begin
         req0 = 1'b1; a0 = a; b0 = b;
      end
      sb_q.push_back(exp);
      @(negedge clk);
      check("op_c0_gnt", 128'({gnt1, gnt0}), 128'(2'b00));
      next_cycle();
      if (perturb) begin
         if (sel) a1 = 64'd0;
         else     a0 = 64'd0;
      end
      @(negedge clk);
      check("op_c1_gnt", 128'({gnt1, gnt0, busy}), 128'({sel, ~sel, 1'b1}));
      next_cycle();
      req0 = 1'b0;
      req1 = 1'b0;
      @(negedge clk);
      check("op_c2_done", 128'({done1, done0}), 128'({sel, ~sel}));
      next_cycle();
      @(negedge clk);
      check("op_c3_idle", 128'({busy, gnt0, gnt1, done0, done1}), 128'(5'b0));
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         check("gnt_mutex", 128'(gnt0 & gnt1), 128'(1'b0));
         check("done_owner", 128'((done0 & ~gnt0) | (done1 & ~gnt1)), 128'(1'b0));
         if (done0 | done1) begin
            if (sb_q.size() == 0) begin
               check("unexpected_done", 128'({done1, done0}), 128'(2'b00));
            end else begin
               sb_exp = sb_q.pop_front();
               check("sb_result", 128'({done1, zf, sf, of, result}), 128'(sb_exp));
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout: sim time %0t exceeded bound", $time);
      $fatal(1);
   end

   initial begin
      n_checks = 0;
      n_errs   = 0;
      rst_n = 1'b0;
      req0 = 1'b0; req1 = 1'b0;
      a0 = '0; b0 = '0; a1 = '0; b1 = '0;
      // {gnt0,gnt1,done0,done1} per cycle for both-requesting-from-reset
      pat_sim = '{4'b0000, 4'b1000, 4'b1010, 4'b0000, 4'b0100,
                  4'b0101, 4'b0000, 4'b1000, 4'b1010};
      pat_rst = '{4'b1000, 4'b1010, 4'b0000, 4'b0100, 4'b0101};

      repeat (3) next_cycle();
      @(negedge clk);
      check("reset_outs", 128'({gnt0, gnt1, busy, done0, done1, zf, sf, of, result}), 128'(0));

      // single request, cycle 0 is the first cycle with rst_n sampled high
      next_cycle();
      rst_n = 1'b1;
      run_op(1'b0, 64'd5, 64'd3, {1'b0, 1'b0, 1'b0, 1'b0, 64'd2}, 1'b0);

      // simultaneous requests straight out of reset
      next_cycle();
      rst_n = 1'b0;
      next_cycle();
      rst_n = 1'b1;
      req0 = 1'b1; a0 = 64'd10; b0 = 64'd10;
      req1 = 1'b1; a1 = 64'd0;  b1 = 64'd1;
      sb_q.push_back({1'b0, 1'b1, 1'b0, 1'b0, 64'd0});
      sb_q.push_back({1'b1, 1'b0, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF});
      sb_q.push_back({1'b0, 1'b1, 1'b0, 1'b0, 64'd0});
      for (int c = 0; c <= 8; c++) begin
         if (c > 0) next_cycle();
         if (c == 8) begin
            req0 = 1'b0;
            req1 = 1'b0;
         end
         @(negedge clk);
         check("sim_pattern", 128'({gnt0, gnt1, done0, done1}), 128'(pat_sim[c]));
      end

      // flags hold while idle
      for (int c = 0; c < 10; c++) begin
         next_cycle();
         @(negedge clk);
         check("flag_hold", 128'({busy, zf, sf, of, result}), 128'({1'b0, 1'b1, 2'b00, 64'd0}));
      end

      next_cycle();
      run_op(1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
             {1'b0, 1'b0, 1'b1, 1'b1, 64'h8000_0000_0000_0000}, 1'b0);
      next_cycle();
      run_op(1'b1, 64'h8000_0000_0000_0000, 64'd1,
             {1'b1, 1'b0, 1'b0, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF}, 1'b1);

      for (int i = 0; i < 6; i++) begin
         logic [63:0] ra, rb;
         logic        rs;
         ra = {$urandom, $urandom};
         rb = (i == 5) ? ra : {$urandom, $urandom};
         rs = i[0];
         next_cycle();
         run_op(rs, ra, rb, expect_sub(rs, ra, rb), 1'b0);
      end

      // reset while in EXEC aborts the operation
      next_cycle();
      req0 = 1'b1; a0 = 64'd100; b0 = 64'd1;
      @(negedge clk);
      next_cycle();
      rst_n = 1'b0;
      @(negedge clk);
      check("abort_exec_gnt0", 128'(gnt0), 128'(1'b1));
      next_cycle();
      rst_n = 1'b1;
      req0 = 1'b1; a0 = 64'd20; b0 = 64'd5;
      req1 = 1'b1; a1 = 64'd3;  b1 = 64'd3;
      sb_q.push_back({1'b0, 1'b0, 1'b0, 1'b0, 64'd15});
      sb_q.push_back({1'b1, 1'b1, 1'b0, 1'b0, 64'd0});
      @(negedge clk);
      check("abort_zeroed", 128'({gnt0, gnt1, busy, done0, done1, zf, sf, of, result}), 128'(0));
      for (int c = 3; c <= 7; c++) begin
         next_cycle();
         if (c == 7) begin
            req0 = 1'b0;
            req1 = 1'b0;
         end
         @(negedge clk);
         check("post_abort_pattern", 128'({gnt0, gnt1, done0, done1}), 128'(pat_rst[c]));
      end

      next_cycle();
      @(negedge clk);
      check("sb_drained", 128'(sb_q.size()), 128'(0));
      $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
      $finish;
   end

endmodule

// File: doc/sub_share_arb.md
Name: sub_share_arb

Overview:
- Arbitrates one shared 64-bit subtract datapath between two requesters, e.g. the execute-stage compare path and the address/bounds-check path.
- Requesters are served round-robin.
- For each request the block latches the operands, computes A - B, and registers the result plus ZF, SF and OF condition flags.
- It signals completion to the requester that owns the operation.
- It sits between the execute-stage control and the subtract/flag logic of the ALU.

Parameters:
- WIDTH, 64, operand/result width. Only 64 is verified.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk.
- req0  input  1  requester 0 request (level).
- a0  input  WIDTH  requester 0 minuend (signed).
- b0  input  WIDTH  requester 0 subtrahend (signed).
- req1  input  1  requester 1 request (level).
- a1  input  WIDTH  requester 1 minuend.
- b1  input  WIDTH  requester 1 subtrahend.
- gnt0  output  1  registered; high while requester 0 owns the datapath.
- gnt1  output  1  registered; high while requester 1 owns the datapath.
- busy  output  1  high in EXEC and DONE states.
- done0  output  1  one-cycle pulse: result/flags valid for requester 0.
- done1  output  1  one-cycle pulse: result/flags valid for requester 1.
- result  output  WIDTH  registered A - B (mod 2^WIDTH).
- zf  output  1  registered: result == 0.
- sf  output  1  registered: result[WIDTH-1].
- of  output  1  registered signed overflow of A - B.

Behaviour:
- Reset: on any rising edge with rst_n=0, regardless of state:
  - state <= IDLE; all outputs <= 0;
  - internal operand registers <= 0;
  - round-robin pointer last <= 1, so requester 0 wins the first tie.
- States: IDLE, EXEC, DONE.
- IDLE:
  - No request: stay in IDLE; gnt*/done* = 0.
  - Exactly one req high: select it.
  - Both high: select the requester not equal to last.
  - On selection, at the edge: latch the selected a/b into opA/opB, set gnt_sel <= 1, last <= sel, go to EXEC.
  - Operands must be valid in the cycle req is first sampled in IDLE; later operand changes are ignored.
- EXEC (1 cycle):
  - At the edge: result <= opA - opB, computed as opA + ~opB + 1, with the carry-out discarded.
  - zf <= (diff == 0); sf <= diff[63].
  - of <= (opA[63] & ~opB[63] & ~diff[63]) | (~opA[63] & opB[63] & diff[63]).
  - done_sel <= 1; go to DONE. gnt_sel stays high.
- DONE (1 cycle):
  - done_sel high for exactly this cycle.
  - At the edge: gnt_sel <= 0, done_sel <= 0, go to IDLE.
- Latency: request sampled in IDLE at cycle N -> gnt at N+1 -> done and valid result at N+2 -> IDLE at N+3. Throughput is one operation per 3 cycles.
- Request protocol: req is level-sensitive and accepted only in IDLE. A requester that keeps req high after its done is treated as making a new request at N+3.
- Round-robin boundary: the pending other requester always wins that next arbitration, so there is no starvation.
- Requests arriving in EXEC/DONE are not lost; they are evaluated at the next IDLE cycle.
- result/zf/sf/of hold their values until the next EXEC edge or reset. They are not cleared on return to IDLE.
- gnt0 and gnt1 are never high together. done0/done1 are high only when the matching gnt is high.
- Reset in EXEC or DONE: the operation is aborted, no done pulse is produced, outputs are zeroed, and last returns to 1.

Test Plan:
- Single request: req0=1, a0=5, b0=3 held from cycle 0 -> gnt0=1 at cycle 1; done0=1 at cycle 2 with result=2, zf=0, sf=0, of=0; gnt0=0 at cycle 3; gnt1/done1 never assert.
- Simultaneous requests from reset: req0=req1=1 (a0=10,b0=10; a1=0,b1=1), both held throughout:
  - done0 at cycle 2 with result=0, zf=1.
  - done1 at cycle 5 with result=0xFFFF_FFFF_FFFF_FFFF, sf=1, of=0.
  - done0 again at cycle 8.
- Overflow: a0=0x7FFF_FFFF_FFFF_FFFF, b0=0xFFFF_FFFF_FFFF_FFFF -> result=0x8000_0000_0000_0000, sf=1, of=1, zf=0.
- Negative overflow: a1=0x8000_0000_0000_0000, b1=1 -> result=0x7FFF_FFFF_FFFF_FFFF, of=1, sf=0. Change a1 to 0 during EXEC -> result unchanged.
- Reset mid-operation: req0 accepted, rst_n=0 in the EXEC cycle -> next cycle all outputs 0, no done0 pulse. With rst_n=1 and req0=req1=1, requester 0 is granted first.
- Flag hold: after a done with zf=1, keep both req low for 10 cycles -> result/zf/sf/of unchanged, busy=0.
